// File: rtl/ofm_write_arbiter.sv
// Round-robin write scheduler for the single OFM write port: one lane granted per
// cycle, each lane writes into its own DEPTH/NUM_LANES region of the OFM.
module ofm_write_arbiter #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_LANES-1:0]        req,
  input  logic [NUM_LANES*DATA_W-1:0] lane_data,
  output logic [NUM_LANES-1:0]        ack,
  output logic                        wr,
  output logic [ADDR_W-1:0]           address,
  output logic [DATA_W-1:0]           wrData,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned REG    = DEPTH / NUM_LANES;
  localparam int unsigned CNT_W  = $clog2(REG) + 1;
  localparam int unsigned TOT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e                          state_q, state_d;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [TOT_W-1:0]                total_q, total_d;
  logic [LANE_W-1:0]               ptr_q, ptr_d;
  logic                            wr_q, wr_d;
  logic [ADDR_W-1:0]               address_q, address_d;
  logic [DATA_W-1:0]               wrdata_q, wrdata_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;

  logic                            found_c;
  logic [LANE_W-1:0]               gnt_c;

  // First requesting lane at or after ptr, wrapping around.
  always_comb begin
    found_c = 1'b0;
    gnt_c   = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (!found_c && req[LANE_W'((32'(ptr_q) + i) % NUM_LANES)]) begin
        found_c = 1'b1;
        gnt_c   = LANE_W'((32'(ptr_q) + i) % NUM_LANES);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    total_d   = total_q;
    ptr_d     = ptr_q;
    wr_d      = 1'b0;
    address_d = address_q;
    wrdata_d  = wrdata_q;
    done_d    = done_q;
    err_d     = err_q;
    ack       = '0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          total_d = '0;
          ptr_d   = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (found_c) begin
          ack[gnt_c] = 1'b1;
          ptr_d      = (32'(gnt_c) == NUM_LANES - 1) ? '0 : gnt_c + LANE_W'(1);
          // A full lane is still acked so it cannot stall; its word is dropped.
          if (cnt_q[gnt_c] == CNT_W'(REG)) begin
            err_d = 1'b1;
          end else begin
            wr_d          = 1'b1;
            address_d     = ADDR_W'(32'(gnt_c) * REG + 32'(cnt_q[gnt_c]));
            wrdata_d      = lane_data[32'(gnt_c) * DATA_W +: DATA_W];
            cnt_d[gnt_c]  = cnt_q[gnt_c] + CNT_W'(1);
            total_d       = total_q + TOT_W'(1);
            if (total_q == TOT_W'(DEPTH - 1)) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      total_q   <= '0;
      ptr_q     <= '0;
      wr_q      <= 1'b0;
      address_q <= '0;
      wrdata_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      total_q   <= total_d;
      ptr_q     <= ptr_d;
      wr_q      <= wr_d;
      address_q <= address_d;
      wrdata_q  <= wrdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr      = wr_q;
  assign address = address_q;
  assign wrData  = wrdata_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ofm_write_arbiter.sv
// Directed bench for ofm_write_arbiter: lane models with req/ack handshake,
// a reference model of the arbitration, and per-scenario checks.
`timescale 1ns/1ps
module tb_ofm_write_arbiter;

  localparam int NL    = 4;
  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 256;
  localparam int REG   = 64;
  localparam int MEMN  = 512;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_FLUSH = 2, ST_DONE = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [NL-1:0]     req = '0;
  logic [NL*DW-1:0]  lane_data = '0;
  logic [NL-1:0]     ack;
  logic              wr;
  logic [AW-1:0]     address;
  logic [DW-1:0]     wrData;
  logic              done;
  logic              err;

  ofm_write_arbiter dut (
    .clk(clk), .rst(rst), .start(start), .req(req), .lane_data(lane_data),
    .ack(ack), .wr(wr), .address(address), .wrData(wrData), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int sent[NL], limit[NL], bcnt[NL];
  int btotal, bptr, bst, salt, wr_count, ack_cyc, done_cyc;
  bit bdone, berr, exp_wr, sparse, done_seen;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [NL-1:0] en_mask = '0, last_ack = '0;
  logic [DW-1:0] mem [MEMN];
  int ack_log[$];
  int addr_log[$];

  function automatic logic [DW-1:0] word(input int lane, input int k);
    return 32'hA000_0000 + DW'(((lane + 2) % 4) << 20) + DW'(salt << 12) + DW'(k);
  endfunction

  task automatic model_clear();
    bst = ST_IDLE; bdone = 0; berr = 0; exp_wr = 0; btotal = 0; bptr = 0;
    for (int i = 0; i < NL; i++) begin bcnt[i] = 0; sent[i] = 0; end
    req = '0; last_ack = '0; start = 1'b0;
  endtask

  // One clock: check registered outputs, drive lanes, check ack, advance the model.
  task automatic cycle(input bit st);
    int g;
    bit fnd;
    logic [NL-1:0] exp_ack;
    @(negedge clk);
    cyc++;
    n_tests++;
    if (wr !== exp_wr) begin
      n_fail++; $display("FAIL wr cyc=%0d got=%b exp=%b", cyc, wr, exp_wr);
    end
    if (exp_wr) begin
      n_tests++;
      if (address !== exp_addr || wrData !== exp_data) begin
        n_fail++;
        $display("FAIL wr_payload cyc=%0d got=%0d/%h exp=%0d/%h", cyc, address, wrData, exp_addr, exp_data);
      end
    end
    if (wr === 1'b1) begin
      wr_count++; mem[address] = wrData; addr_log.push_back(int'(address));
    end
    n_tests++;
    if (done !== bdone) begin
      n_fail++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, bdone);
    end
    if (done === 1'b1 && !done_seen) begin done_seen = 1; done_cyc = cyc; end
    n_tests++;
    if (err !== berr) begin
      n_fail++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, berr);
    end
    start = st;
    for (int i = 0; i < NL; i++) begin
      if (last_ack[i]) req[i] = 1'b0;
      if (!req[i] && en_mask[i] && sent[i] < limit[i] && (!sparse || $urandom_range(2) == 0))
        req[i] = 1'b1;
      lane_data[i*DW +: DW] = word(i, sent[i]);
    end
    #1;
    fnd = 0; g = 0; exp_ack = '0;
    if (bst == ST_RUN) begin
      for (int j = 0; j < NL; j++) begin
        if (!fnd && req[(bptr + j) % NL]) begin fnd = 1; g = (bptr + j) % NL; end
      end
    end
    if (fnd) exp_ack[g] = 1'b1;
    n_tests++;
    if (ack !== exp_ack) begin
      n_fail++; $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, ack, exp_ack);
    end
    last_ack = exp_ack;
    exp_wr = 0;
    if (fnd) begin
      ack_log.push_back(g);
      bptr = (g + 1) % NL;
      if (bcnt[g] == REG) berr = 1;
      else begin
        exp_wr = 1; exp_addr = AW'(g * REG + bcnt[g]); exp_data = word(g, sent[g]);
        bcnt[g]++; btotal++;
        if (btotal == DEPTH) ack_cyc = cyc;
      end
      sent[g]++;
    end
    case (bst)
      ST_IDLE, ST_DONE: if (st) begin
        bst = ST_RUN; btotal = 0; bptr = 0; berr = 0; bdone = 0;
        for (int i = 0; i < NL; i++) bcnt[i] = 0;
      end
      ST_RUN:   if (btotal == DEPTH) bst = ST_FLUSH;
      ST_FLUSH: begin bst = ST_DONE; bdone = 1; end
      default: ;
    endcase
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (bst != ST_DONE && n < budget) begin cycle(1'b0); n++; end
    n_tests++;
    if (bst != ST_DONE) begin n_fail++; $display("FAIL layer_timeout got=%0d cycles exp=<%0d", n, budget); end
    cycle(1'b0);
  endtask

  task automatic run_until_sent(input int lane, input int target, input int budget);
    int n = 0;
    while (sent[lane] < target && n < budget) begin cycle(1'b0); n++; end
    n_tests++;
    if (sent[lane] < target) begin n_fail++; $display("FAIL lane_timeout got=%0d exp=%0d", sent[lane], target); end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_limits(input int l0, input int l1, input int l2, input int l3);
    limit[0] = l0; limit[1] = l1; limit[2] = l2; limit[3] = l3;
  endtask

  task automatic test_reset();
    model_clear(); sparse = 0; salt = 1; en_mask = '0; set_limits(64, 64, 64, 64);
    rst = 1'b0;
    #1;
    n_tests++;
    if ({wr, done, err} !== 3'b000 || ack !== '0 || address !== '0 || wrData !== '0) begin
      n_fail++; $display("FAIL reset_values got=wr%b d%b e%b ack%b a%0d w%h exp=all zero", wr, done, err, ack, address, wrData);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    en_mask = 4'hF;
    run_cycles(3);
  endtask

  task automatic test_all_lanes();
    int exp_first[5];
    exp_first = '{0, 64, 128, 192, 1};
    ack_log.delete(); addr_log.delete(); wr_count = 0; done_seen = 0;
    cycle(1'b1);
    run_to_done(400);
    for (int j = 0; j < 5; j++) begin
      n_tests++;
      if (addr_log.size() <= j || addr_log[j] != exp_first[j]) begin
        n_fail++; $display("FAIL all_lanes_addr[%0d] got=%0d exp=%0d", j, (addr_log.size() > j) ? addr_log[j] : -1, exp_first[j]);
      end
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (ack_log.size() <= j || ack_log[j] != j % NL) begin
        n_tests++; n_fail++;
        $display("FAIL all_lanes_order[%0d] got=%0d exp=%0d", j, (ack_log.size() > j) ? ack_log[j] : -1, j % NL);
        break;
      end
    end
    n_tests++;
    if (wr_count != DEPTH) begin n_fail++; $display("FAIL all_lanes_wr_count got=%0d exp=%0d", wr_count, DEPTH); end
    n_tests++;
    if (!done_seen || done_cyc - ack_cyc != 2) begin
      n_fail++; $display("FAIL done_latency got=%0d exp=2", done_seen ? done_cyc - ack_cyc : -1);
    end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL all_lanes_err got=%b exp=0", err); end
  endtask

  task automatic test_start_in_done();
    salt = 2; wr_count = 0;
    for (int i = 0; i < NL; i++) sent[i] = 0;
    cycle(1'b1);
    cycle(1'b0);
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done_drop got=%b exp=0", done); end
    run_to_done(400);
    n_tests++;
    if (wr_count != DEPTH) begin n_fail++; $display("FAIL restart_wr_count got=%0d exp=%0d", wr_count, DEPTH); end
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done got=%b exp=1", done); end
  endtask

  task automatic test_single_lane();
    salt = 0; en_mask = 4'b0100; set_limits(0, 0, 64, 0);
    for (int i = 0; i < MEMN; i++) mem[i] = '0;
    for (int i = 0; i < NL; i++) sent[i] = 0;
    cycle(1'b1);
    run_until_sent(2, 64, 200);
    run_cycles(4);
    for (int k = 0; k < REG; k++) begin
      n_tests++;
      if (mem[128 + k] !== 32'hA000_0000 + 32'(k)) begin
        n_fail++; $display("FAIL lane2_mem[%0d] got=%h exp=%h", 128 + k, mem[128 + k], 32'hA000_0000 + 32'(k));
      end
    end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL lane2_done got=%b exp=0", done); end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    int exp_base[4];
    exp_base = '{0, 64, 128, 192};
    apply_reset();
    salt = 3; en_mask = 4'hF; set_limits(64, 64, 64, 64);
    cycle(1'b1);
    while (btotal < 100 && n < 300) begin cycle(1'b0); n++; end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({wr, done, err} !== 3'b000 || ack !== '0 || address !== '0) begin
      n_fail++; $display("FAIL async_reset got=wr%b d%b e%b ack%b a%0d exp=all zero", wr, done, err, ack, address);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    addr_log.delete();
    cycle(1'b1);
    run_cycles(6);
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (addr_log.size() <= j || addr_log[j] != exp_base[j]) begin
        n_fail++; $display("FAIL restart_base[%0d] got=%0d exp=%0d", j, (addr_log.size() > j) ? addr_log[j] : -1, exp_base[j]);
      end
    end
  endtask

  task automatic test_overfill();
    int exp_ord[8];
    exp_ord = '{2, 3, 0, 1, 2, 3, 0, 1};
    apply_reset();
    salt = 1; en_mask = 4'b0010; set_limits(0, 65, 0, 0); wr_count = 0;
    cycle(1'b1);
    run_until_sent(1, 65, 200);
    run_cycles(2);
    n_tests++;
    if (wr_count != 64) begin n_fail++; $display("FAIL overfill_wr_count got=%0d exp=64", wr_count); end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL overfill_err got=%b exp=1", err); end
    set_limits(2, 67, 2, 2); en_mask = 4'hF; ack_log.delete();
    run_cycles(10);
    for (int j = 0; j < 8; j++) begin
      n_tests++;
      if (ack_log.size() <= j || ack_log[j] != exp_ord[j]) begin
        n_fail++; $display("FAIL overfill_rr[%0d] got=%0d exp=%0d", j, (ack_log.size() > j) ? ack_log[j] : -1, exp_ord[j]);
      end
    end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL overfill_err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_sparse();
    apply_reset();
    salt = 2; en_mask = 4'hF; set_limits(64, 64, 64, 64); sparse = 1; wr_count = 0;
    for (int i = 0; i < MEMN; i++) mem[i] = '0;
    cycle(1'b1);
    run_to_done(3000);
    sparse = 0;
    for (int i = 0; i < NL; i++) begin
      for (int k = 0; k < REG; k++) begin
        n_tests++;
        if (mem[i * REG + k] !== word(i, k)) begin
          n_fail++; $display("FAIL sparse_mem[%0d] got=%h exp=%h", i * REG + k, mem[i * REG + k], word(i, k));
        end
      end
    end
    n_tests++;
    if (wr_count != DEPTH) begin n_fail++; $display("FAIL sparse_wr_count got=%0d exp=%0d", wr_count, DEPTH); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL sparse_err got=%b exp=0", err); end
  endtask

  initial begin
    test_reset();
    test_all_lanes();
    test_start_in_done();
    test_single_lane();
    test_mid_reset();
    test_overfill();
    test_sparse();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ofm_write_arbiter.md
# ofm_write_arbiter

Round-robin write scheduler for the single write port of the OFM memory in the convolution datapath. Up to NUM_LANES processing lanes present 32-bit results on a req/ack handshake. The block grants one lane per cycle and generates the OFM address from a per-lane region counter. It drives the OFM `wr`/`address`/`wrData` port and raises `done` once all DEPTH words are written, which triggers the OFM dump.

## Interface
- NUM_LANES, 4, number of requesting lanes; must divide DEPTH
- DATA_W, 32, result word width
- ADDR_W, 9, OFM address width
- DEPTH, 256, OFM words per layer; region size REG = DEPTH/NUM_LANES (64 by default)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse that begins a layer
- req  input  NUM_LANES  lane i holds a result valid
- lane_data  input  NUM_LANES*DATA_W  packed results, lane i at bits [i*DATA_W +: DATA_W]
- ack  output  NUM_LANES  one-hot, combinational; the granted lane's word is taken this cycle
- wr  output  1  OFM write enable, registered
- address  output  ADDR_W  OFM write address, registered
- wrData  output  DATA_W  OFM write data, registered
- done  output  1  layer complete, sticky until next start
- err  output  1  sticky overflow flag

## Operation
- State machine IDLE -> RUN -> FLUSH -> DONE.
- Reset (rst=0, any time, asynchronous): state IDLE, wr=0, address=0, wrData=0, done=0, err=0, RR pointer=0, all lane counters=0, total=0. ack=0 in IDLE.
- IDLE: ack=0, wr=0. start=1 -> RUN; counters, total, pointer and err cleared.
- RUN: arbitration each cycle.
  - Search starts at lane `ptr` and wraps modulo NUM_LANES; the first lane with req=1 is granted g.
  - ack[g]=1 in the same cycle.
  - Next cycle: wr=1, address=g*REG+cnt[g], wrData=lane_data[g].
  - cnt[g] and total each increment by 1; ptr becomes (g+1) mod NUM_LANES.
  - No req: ack=0, the next cycle has wr=0, and ptr is unchanged.
  - start while in RUN is ignored.
- Full lane (cnt[g]==REG):
  - The lane stays eligible, is acked, and its word is dropped: no wr, no counter change.
  - err is set sticky.
  - ptr still advances, so a full lane cannot starve the others.
- Completion: the grant that makes total==DEPTH moves the FSM to FLUSH. That grant's wr appears on the FLUSH cycle, and ack=0 in FLUSH.
- FLUSH -> DONE unconditionally. done=1 from the DONE cycle onward, one cycle after the last wr, so the final word is in memory before the dump fires.
- DONE: ack=0, wr=0, done held. start=1 -> RUN with everything cleared and done=0 on the next cycle.
- Widths:
  - cnt is log2(REG)+1 bits, so it can hold REG.
  - total is log2(DEPTH)+1 bits.
  - address = lane*REG + cnt, truncated to ADDR_W. Address DEPTH and above is never generated.

## Timing
- Handshake: a lane asserts req and holds lane_data stable until it sees ack high at a clock edge. It may drop req or present the next word on the following cycle. req is never withdrawn without ack.
- Latency: ack in cycle N -> wr/address/wrData valid in cycle N+1.
- Throughput: 1 word per cycle when any req is present.
- Fairness: with all lanes continuously requesting, grants follow 0,1,2,3,0,... starting from ptr=0.
- wr is high for exactly one cycle per accepted word; address and wrData hold their last value while wr=0.
- done rises exactly 2 cycles after the ack of the DEPTH-th accepted word.
- Reset mid-RUN: all outputs return to reset values immediately, with no partial completion. A fresh start is required.

## Test plan
- All 4 lanes req continuously after start.
  - Required: ack order 0,1,2,3 repeating.
  - Required: addresses 0,64,128,192,1,65,..., with 256 wr pulses.
  - Required: done exactly 2 cycles after the 256th ack; err=0.
- Only lane 2 requesting, 64 words with data = 0xA0000000+k.
  - Required: mem[128+k] = 0xA0000000+k for every k.
  - Required: total stays 64 and done stays 0.
- Lane 1 overfilled to 65 requests.
  - Required: the 65th is acked with no wr, err=1 sticky.
  - Required: other lanes still granted round-robin afterwards.
- Sparse random req over 4 lanes.
  - Required: each lane's word k is written to lane*64+k in order, with no lost or duplicated words.
  - Required: done after 256 writes.
- Reset asserted mid-RUN, after 100 writes.
  - Required: wr=0, ack=0, done=0, err=0 asynchronously.
  - Then start: counters restart at region bases 0/64/128/192.
- start in DONE.
  - Required: done drops the next cycle.
  - Required: the second layer writes a full 256 words and re-asserts done.
